// File: rtl/syn_dff_core_pkg.sv
// Shared defaults and types for the syn_dff_core register stage.
package syn_dff_core_pkg;

  localparam int DEF_WIDTH          = 1;
  localparam int DEF_STAGES         = 1;
  localparam int DEF_RST_SYNC_DEPTH = 2;

  // Stage array for the default configuration, for use by checker modules.
  typedef logic [DEF_WIDTH-1:0] def_stage_arr_t [DEF_STAGES];

endpackage

// File: rtl/syn_dff_core_rst_sync.sv
// Reset synchronizer: asserts asynchronously, releases after DEPTH rising clk edges.
module syn_dff_core_rst_sync
  import syn_dff_core_pkg::*;
#(
  parameter int DEPTH = DEF_RST_SYNC_DEPTH
) (
  input  logic clk,
  input  logic rst,
  output logic rst_out
);

  logic [DEPTH-1:0] sync_d;
  logic [DEPTH-1:0] sync_q;

  // Shift zeros in behind the released reset.
  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], 1'b0};
  end

  // Synchronizer flops, set immediately on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {DEPTH{1'b1}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_out = sync_q[DEPTH-1];

endmodule

// File: rtl/syn_dff_core.sv
// Resettable register pipeline of STAGES flops from d to q.
// Define SYN_DFF_CORE_RST_SYNC_EN to release reset through a 2-flop synchronizer.
module syn_dff_core
  import syn_dff_core_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               STAGES    = DEF_STAGES,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic stage_rst;

`ifdef SYN_DFF_CORE_RST_SYNC_EN
  syn_dff_core_rst_sync #(
    .DEPTH(DEF_RST_SYNC_DEPTH)
  ) u_rst_sync (
    .clk    (clk),
    .rst    (rst),
    .rst_out(stage_rst)
  );
`else
  assign stage_rst = rst;
`endif

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic [WIDTH-1:0] stage_d;
    logic [WIDTH-1:0] stage_q;

    if (g == 0) begin : g_first
      always_comb begin
        stage_d = d;
      end
    end else begin : g_next
      always_comb begin
        stage_d = g_stage[g-1].stage_q;
      end
    end

    // One pipeline stage; reset overrides the clock.
    always_ff @(posedge clk or posedge stage_rst) begin
      if (stage_rst) begin
        stage_q <= RESET_VAL;
      end else begin
        stage_q <= stage_d;
      end
    end
  end

  assign q = g_stage[STAGES-1].stage_q;

endmodule

// File: tb/tb_syn_dff_core.sv
// Scoreboard bench for syn_dff_core: a 1-bit single-stage instance and an
// 8-bit three-stage instance with a non-zero reset value.
module tb_syn_dff_core;

`ifdef SYN_DFF_CORE_RST_SYNC_EN
  localparam int SYNC_EDGES = 2;
`else
  localparam int SYNC_EDGES = 0;
`endif
  localparam logic [7:0] RV1 = 8'hA5;

  logic       clk = 1'b0;
  logic       rst0, rst1;
  logic       d0;
  logic [7:0] d1;
  logic       q0;
  logic [7:0] q1;

  int n_checks = 0;
  int n_errors = 0;

  syn_dff_core u_dut0 (
    .clk(clk), .rst(rst0), .d(d0), .q(q0)
  );

  syn_dff_core #(.WIDTH(8), .STAGES(3), .RESET_VAL(RV1)) u_dut1 (
    .clk(clk), .rst(rst1), .d(d1), .q(q1)
  );

  always #20 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state and expected-output queues
  logic       m0;
  int         h0 = 0;
  bit         armed0 = 1'b0;
  logic [7:0] m1 [3];
  int         h1 = 0;
  bit         armed1 = 1'b0;
  logic       exp_q0 [$];
  logic [7:0] exp_q1 [$];

  // Resets are only raised while clk is low, so clk high marks a clock edge here.
  always @(posedge clk or posedge rst0) begin
    if (rst0) begin
      m0 = 1'b0;
      h0 = SYNC_EDGES;
      armed0 = 1'b1;
    end else if (h0 > 0) begin
      h0--;
    end else begin
      m0 = d0;
    end
    if (clk && armed0) exp_q0.push_back(m0);
  end

  always @(posedge clk or posedge rst1) begin
    if (rst1) begin
      for (int i = 0; i < 3; i++) m1[i] = RV1;
      h1 = SYNC_EDGES;
      armed1 = 1'b1;
    end else if (h1 > 0) begin
      h1--;
    end else begin
      m1[2] = m1[1];
      m1[1] = m1[0];
      m1[0] = d1;
    end
    if (clk && armed1) exp_q1.push_back(m1[2]);
  end

  // Compare DUT outputs shortly after each rising edge
  always @(posedge clk) begin
    #1;
    if (exp_q0.size() > 0) check_eq("q0_edge", {7'd0, q0}, {7'd0, exp_q0.pop_front()});
    if (exp_q1.size() > 0) check_eq("q1_edge", q1, exp_q1.pop_front());
  end

  task automatic stream_random(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      d0 = 1'($urandom_range(0, 1));
      d1 = 8'($urandom_range(0, 255));
      // extra mid-cycle glitch on d that must never be captured
      #7 d0 = ~d0;
      #3 d0 = ~d0;
    end
  endtask

  initial begin
    rst0 = 1'b0;
    rst1 = 1'b0;
    d0   = 1'b1;
    d1   = 8'h00;

    // Async reset assertion without any clock edge
    #10 rst0 = 1'b1;
    rst1 = 1'b1;
    #2 check_eq("rst_async_q0", {7'd0, q0}, 8'h00);
    check_eq("rst_async_q1", q1, RV1);

    // Directed d pattern with glitches between edges
    #13 d0 = 1'b0;                 // 25 ns
    #5  rst0 = 1'b0;               // 30 ns
    rst1 = 1'b0;
    #10 d0 = 1'b1; d1 = 8'h01;     // 40 ns
    #25 d0 = 1'b0; d1 = 8'h02;     // 65 ns
    #25 d0 = 1'b1;                 // 90 ns
    #20 d1 = 8'h03;                // 110 ns
    #5  d0 = 1'b0;                 // 115 ns
    #30 d0 = 1'b1; d1 = 8'h00;     // 145 ns

    stream_random(12);

    // Short reset pulse in the low phase while data is streaming
    @(negedge clk);
    #5 rst0 = 1'b1;
    rst1 = 1'b1;
    #2 check_eq("pulse_q0", {7'd0, q0}, 8'h00);
    check_eq("pulse_q1", q1, RV1);
    #3 rst0 = 1'b0;
    rst1 = 1'b0;

    stream_random(10);

    // Reset released in the same timestep as a rising edge; that edge must not capture
    @(negedge clk);
    d0 = 1'b1;
    d1 = 8'h5A;
    rst0 = 1'b1;
    rst1 = 1'b1;
    @(posedge clk);
    rst0 <= 1'b0;
    rst1 <= 1'b0;
    #2 check_eq("coinc_q0", {7'd0, q0}, 8'h00);
    check_eq("coinc_q1", q1, RV1);

    stream_random(10);

    @(negedge clk);
    check_eq("sb_q0_drained", 8'(exp_q0.size()), 8'd0);
    check_eq("sb_q1_drained", 8'(exp_q1.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
